// File: rtl/alu_vector_checker.sv
// alu_vector_checker
// Drives one test vector at a time into an external ALU, holds the operands
// for SETTLE_CYCLES cycles, then samples {Zero, BusW}, compares it against the
// vector's expected value and keeps saturating pass/test totals.
//
// Ports
//   Clk, Reset            clock and synchronous active-high reset
//   VecValid/VecReady     vector handshake (accepted when both high)
//   VecA, VecB, VecCtrl   operands and control code of the offered vector
//   VecExp                expected {Zero, BusW}
//   BusA, BusB, ALUCtrl   registered drive of the ALU under test
//   BusW, Zero            ALU results
//   ResValid              one-cycle strobe, ResPass/ResActual valid with it
//   ResPass, ResActual    compare outcome and sampled {Zero, BusW} (held)
//   PassCount, TestCount  saturating running totals
//   Clear                 zero the totals
//   AllPassed             at least one test ran and every one of them passed
module alu_vector_checker #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        VecValid,
  output logic        VecReady,
  input  logic [63:0] VecA,
  input  logic [63:0] VecB,
  input  logic [3:0]  VecCtrl,
  input  logic [64:0] VecExp,
  output logic [63:0] BusA,
  output logic [63:0] BusB,
  output logic [3:0]  ALUCtrl,
  input  logic [63:0] BusW,
  input  logic        Zero,
  output logic        ResValid,
  output logic        ResPass,
  output logic [64:0] ResActual,
  output logic [7:0]  PassCount,
  output logic [7:0]  TestCount,
  input  logic        Clear,
  output logic        AllPassed
);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK} stateT;

  // DRIVE lasts SETTLE_CYCLES-1 cycles and CHECK one more, so the operands
  // have been on the bus for SETTLE_CYCLES cycles when the sample is taken.
  // With a single settle cycle the DRIVE phase disappears entirely.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam bit         SKIP_DRIVE  = (SETTLE_CYCLES == 1);

  stateT       state;
  stateT       nextState;
  logic [3:0]  settleCount;
  logic [64:0] expReg;
  logic [64:0] sample;
  logic        accept;
  logic        isCheck;
  logic        match;

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic; the DRIVE exit fires when the count is about to hit 0
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (VecValid) nextState = SKIP_DRIVE ? CHECK : DRIVE;
      DRIVE:   if (settleCount <= 4'd1) nextState = CHECK;
      CHECK:   nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    VecReady = (state == IDLE);
    isCheck  = (state == CHECK);
    accept   = (state == IDLE) && VecValid;
  end

  assign sample = {Zero, BusW};
  assign match  = (sample == expReg);

  // Settle counter
  always_ff @(posedge Clk) begin
    if (Reset) begin
      settleCount <= '0;
    end else if (accept) begin
      settleCount <= SETTLE_LOAD;
    end else if (state == DRIVE && settleCount != 4'd0) begin
      settleCount <= settleCount - 4'd1;
    end
  end

  // Vector registers: only an acceptance changes what the ALU sees
  always_ff @(posedge Clk) begin
    if (Reset) begin
      BusA    <= '0;
      BusB    <= '0;
      ALUCtrl <= '0;
      expReg  <= '0;
    end else if (accept) begin
      BusA    <= VecA;
      BusB    <= VecB;
      ALUCtrl <= VecCtrl;
      expReg  <= VecExp;
    end
  end

  // Result capture; ResActual/ResPass persist until the next check
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ResValid  <= 1'b0;
      ResPass   <= 1'b0;
      ResActual <= '0;
    end else begin
      ResValid <= isCheck;
      if (isCheck) begin
        ResActual <= sample;
        ResPass   <= match;
      end
    end
  end

  // Saturating totals; Clear wins over a coincident check
  always_ff @(posedge Clk) begin
    if (Reset || Clear) begin
      TestCount <= '0;
      PassCount <= '0;
    end else if (isCheck) begin
      if (TestCount != 8'hFF) TestCount <= TestCount + 8'd1;
      if (match && PassCount != 8'hFF) PassCount <= PassCount + 8'd1;
    end
  end

  assign AllPassed = (TestCount != 8'd0) && (PassCount == TestCount);

endmodule

// File: tb/tb_alu_vector_checker.sv
// tb_alu_vector_checker
// Randomized self-checking bench for alu_vector_checker. A behavioural ALU is
// attached to the DUT buses; the reference model predicts each result from
// the offered operands and tracks the saturating totals with plain integers.
module tb_alu_vector_checker;

  localparam int SETTLE = 4;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        VecValid;
  logic        VecReady;
  logic [63:0] VecA;
  logic [63:0] VecB;
  logic [3:0]  VecCtrl;
  logic [64:0] VecExp;
  logic [63:0] BusA;
  logic [63:0] BusB;
  logic [3:0]  ALUCtrl;
  logic [63:0] BusW;
  logic        Zero;
  logic        ResValid;
  logic        ResPass;
  logic [64:0] ResActual;
  logic [7:0]  PassCount;
  logic [7:0]  TestCount;
  logic        Clear;
  logic        AllPassed;

  int checkCount = 0;
  int errorCount = 0;
  int cycleCount = 0;
  int lastAccept = 0;
  int mTest = 0;
  int mPass = 0;

  alu_vector_checker #(.SETTLE_CYCLES(SETTLE)) dut (
    .Clk(Clk), .Reset(Reset), .VecValid(VecValid), .VecReady(VecReady),
    .VecA(VecA), .VecB(VecB), .VecCtrl(VecCtrl), .VecExp(VecExp),
    .BusA(BusA), .BusB(BusB), .ALUCtrl(ALUCtrl), .BusW(BusW), .Zero(Zero),
    .ResValid(ResValid), .ResPass(ResPass), .ResActual(ResActual),
    .PassCount(PassCount), .TestCount(TestCount), .Clear(Clear),
    .AllPassed(AllPassed)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cycleCount = cycleCount + 1;

  // Behavioural ALU: AND, OR, ADD, SUB, PassB; other codes produce 0
  function automatic logic [63:0] aluModel(input logic [63:0] a, input logic [63:0] b,
                                           input logic [3:0] ctrl);
    case (ctrl)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd6:    return a - b;
      4'd7:    return b;
      default: return 64'd0;
    endcase
  endfunction

  assign BusW = aluModel(BusA, BusB, ALUCtrl);
  assign Zero = (BusW == 64'd0);

  function automatic logic [64:0] expectedResult(input logic [63:0] a, input logic [63:0] b,
                                                 input logic [3:0] ctrl);
    logic [63:0] r;
    r = aluModel(a, b, ctrl);
    return {r == 64'd0, r};
  endfunction

  task automatic checkOutput(input string tag, input logic [64:0] actual,
                             input logic [64:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, actual, expected);
    end
  endtask

  // Offer a vector and wait for its acceptance edge
  task automatic acceptVector(input logic [63:0] a, input logic [63:0] b,
                              input logic [3:0] ctrl, input logic [64:0] exp,
                              input bit checkSpacing);
    int waitCycles;
    waitCycles = 0;
    @(negedge Clk);
    VecA = a; VecB = b; VecCtrl = ctrl; VecExp = exp; VecValid = 1'b1;
    while (!VecReady && waitCycles < 100) begin
      @(negedge Clk);
      waitCycles++;
    end
    if (!VecReady) checkOutput("readyTimeout", 65'd0, 65'd1);
    @(posedge Clk);
    #1;
    if (checkSpacing) checkOutput("spacing", 65'(cycleCount - lastAccept), 65'(SETTLE + 1));
    lastAccept = cycleCount;
    checkOutput("busA", 65'(BusA), 65'(a));
    checkOutput("busB", 65'(BusB), 65'(b));
    checkOutput("aluCtrl", 65'(ALUCtrl), 65'(ctrl));
    checkOutput("readyAfterAccept", 65'(VecReady), 65'd0);
    // Garbage offered while busy must be ignored
    VecA = {$urandom, $urandom};
    VecB = {$urandom, $urandom};
    VecCtrl = 4'($urandom);
    VecExp = {1'b1, $urandom, $urandom};
  endtask

  // Wait for the result strobe and check it against the model
  task automatic finishVector(input logic [63:0] a, input logic [63:0] b,
                              input logic [3:0] ctrl, input logic [64:0] exp,
                              input bit keepValid, input bit clearAtCheck);
    int n;
    logic [64:0] want;
    bit pass;
    n = 0;
    want = expectedResult(a, b, ctrl);
    pass = (want == exp);
    while (n < 50) begin
      if (clearAtCheck && n == SETTLE - 1) Clear = 1'b1;
      @(posedge Clk);
      #1;
      n++;
      if (ResValid) break;
      checkOutput("readyBusy", 65'(VecReady), 65'd0);
    end
    Clear = 1'b0;
    if (!keepValid) VecValid = 1'b0;
    checkOutput("resValid", 65'(ResValid), 65'd1);
    checkOutput("latency", 65'(n), 65'(SETTLE));
    checkOutput("resPass", 65'(ResPass), 65'(pass));
    checkOutput("resActual", ResActual, want);
    checkOutput("busAHeld", 65'(BusA), 65'(a));
    checkOutput("readyIdle", 65'(VecReady), 65'd1);
    if (clearAtCheck) begin
      mTest = 0;
      mPass = 0;
    end else begin
      if (mTest < 255) mTest++;
      if (pass && mPass < 255) mPass++;
    end
    checkOutput("testCount", 65'(TestCount), 65'(mTest));
    checkOutput("passCount", 65'(PassCount), 65'(mPass));
    checkOutput("allPassed", 65'(AllPassed), 65'(mTest != 0 && mPass == mTest));
  endtask

  task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b,
                               input logic [3:0] ctrl, input logic [64:0] exp,
                               input bit checkSpacing, input bit keepValid,
                               input bit clearAtCheck);
    acceptVector(a, b, ctrl, exp, checkSpacing);
    finishVector(a, b, ctrl, exp, keepValid, clearAtCheck);
  endtask

  task automatic clearCounters();
    @(negedge Clk);
    Clear = 1'b1;
    @(posedge Clk);
    #1;
    Clear = 1'b0;
    mTest = 0;
    mPass = 0;
    checkOutput("clearTest", 65'(TestCount), 65'd0);
    checkOutput("clearPass", 65'(PassCount), 65'd0);
  endtask

  function automatic logic [3:0] pickCtrl(input bit legalOnly);
    logic [3:0] codes [7];
    codes = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd3, 4'd15};
    return legalOnly ? codes[$urandom_range(0, 4)] : codes[$urandom_range(0, 6)];
  endfunction

  initial begin
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  c;
    logic [64:0] e;
    int releaseCycle;
    bit sawValid;

    Reset = 1'b1; VecValid = 1'b0; Clear = 1'b0;
    VecA = '0; VecB = '0; VecCtrl = '0; VecExp = '0;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    releaseCycle = cycleCount;
    checkOutput("rstBusA", 65'(BusA), 65'd0);
    checkOutput("rstBusB", 65'(BusB), 65'd0);
    checkOutput("rstCtrl", 65'(ALUCtrl), 65'd0);
    checkOutput("rstActual", ResActual, 65'd0);
    checkOutput("rstValid", 65'(ResValid), 65'd0);
    checkOutput("rstPass", 65'(ResPass), 65'd0);
    checkOutput("rstTest", 65'(TestCount), 65'd0);
    checkOutput("rstPassCnt", 65'(PassCount), 65'd0);
    checkOutput("rstAllPassed", 65'(AllPassed), 65'd0);
    checkOutput("rstReady", 65'(VecReady), 65'd1);

    // Directed ADD vector, accepted in the first cycle out of reset
    acceptVector(64'h1234, 64'hABCD0000, 4'd2, 65'h0ABCD1234, 1'b0);
    checkOutput("firstAccept", 65'(lastAccept), 65'(releaseCycle + 1));
    finishVector(64'h1234, 64'hABCD0000, 4'd2, 65'h0ABCD1234, 1'b0, 1'b0);

    // Zero flag set, then the same vector with a wrong expectation
    applyStimulus(64'd0, 64'd0, 4'd6, 65'h1_0000_0000_0000_0000, 1'b0, 1'b0, 1'b0);
    checkOutput("zeroBit", 65'(ResActual[64]), 65'd1);
    clearCounters();
    applyStimulus(64'd0, 64'd0, 4'd6, 65'h1_0000_0000_0000_0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(64'd0, 64'd0, 4'd6, 65'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("failActual", ResActual, 65'h1_0000_0000_0000_0000);

    // Seventeen back-to-back passing vectors with VecValid held high
    clearCounters();
    for (int i = 0; i < 17; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      c = pickCtrl(1'b1);
      e = expectedResult(a, b, c);
      applyStimulus(a, b, c, e, i > 0, i < 16, 1'b0);
    end
    checkOutput("b2bTotal", 65'(TestCount), 65'd17);

    // Reset in DRIVE aborts the vector
    acceptVector(64'h55, 64'h0F, 4'd0, 65'h05, 1'b0);
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    Reset = 1'b1; VecValid = 1'b0;
    @(posedge Clk); #1;
    Reset = 1'b0;
    mTest = 0; mPass = 0;
    checkOutput("abortBusA", 65'(BusA), 65'd0);
    checkOutput("abortCtrl", 65'(ALUCtrl), 65'd0);
    checkOutput("abortTest", 65'(TestCount), 65'd0);
    sawValid = 1'b0;
    repeat (SETTLE + 3) begin
      @(posedge Clk); #1;
      if (ResValid) sawValid = 1'b1;
    end
    checkOutput("abortNoValid", 65'(sawValid), 65'd0);
    checkOutput("abortPassCnt", 65'(PassCount), 65'd0);
    applyStimulus(64'h55, 64'h0F, 4'd0, 65'h05, 1'b0, 1'b0, 1'b0);

    // Random mix including odd control codes and corrupted expectations
    for (int i = 0; i < 30; i++) begin
      a = {$urandom, $urandom};
      b = ($urandom_range(0, 4) == 0) ? a : {$urandom, $urandom};
      c = pickCtrl(1'b0);
      e = expectedResult(a, b, c);
      if ($urandom_range(0, 3) == 0) e = e ^ (65'd1 << $urandom_range(0, 64));
      applyStimulus(a, b, c, e, 1'b0, 1'b0, 1'b0);
    end

    // Saturation at 255, then Clear coinciding with a check
    clearCounters();
    for (int i = 0; i < 260; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      c = pickCtrl(1'b1);
      e = expectedResult(a, b, c);
      applyStimulus(a, b, c, e, i > 0, i < 259, 1'b0);
    end
    checkOutput("satTest", 65'(TestCount), 65'd255);
    checkOutput("satPass", 65'(PassCount), 65'd255);
    applyStimulus(64'd7, 64'd9, 4'd1, 65'h0F, 1'b0, 1'b0, 1'b1);
    @(posedge Clk); #1;
    checkOutput("strobeDrop", 65'(ResValid), 65'd0);
    checkOutput("holdPass", 65'(ResPass), 65'd1);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
